bus_datapath_seq: RTL and testbench
===================================

# bus_datapath_seq

Parametrised single-bus datapath core with an internal control-step sequencer. It executes one register-transfer instruction per issue handshake: operand to Y, ALU to Z, Z to destination. It also runs an iterative unsigned multiply into HI/LO. It sits between the instruction decoder and the register/ALU resources, replacing hand-driven per-step control strobes with an issue/done interface.

## Interface
- DATA_W, 32, datapath width in bits (≥ 8).
- NUM_REGS, 16, general register count (power of 2, ≥ 2); R0 is hard-wired zero.
- RA_W, clog2(NUM_REGS), register-index width (derived, not overridden).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- clr  in  1  reset, synchronous and active-high.
- issue_valid  in  1  instruction offered.
- issue_ready  out  1  core idle and able to accept.
- op  in  4  opcode (see Operation).
- ra  in  RA_W  destination register index.
- rb  in  RA_W  first source register index.
- rc  in  RA_W  second source register index.
- imm  in  DATA_W  immediate for ADDI.
- in_port_data  in  DATA_W  external input port value.
- out_port_data  out  DATA_W  output port register.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse with done for an illegal opcode.
- dbg_sel  in  RA_W  debug register select.
- dbg_data  out  DATA_W  combinational read of R[dbg_sel] (R0 reads 0).
- hi_data, lo_data  out  DATA_W each  HI/LO register contents.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR: R[ra] ← R[rb] op R[rc].
  - 4 SHL, 5 SHR: logical shift of R[rb] by R[rc][clog2(DATA_W)-1:0].
  - 6 ADDI: R[ra] ← R[rb] + imm.
  - 7 MUL: {HI,LO} ← R[rb] × R[rc], unsigned.
  - 8 MFHI: R[ra] ← HI. 9 MFLO: R[ra] ← LO.
  - 10 IN: R[ra] ← in_port_data. 11 OUT: out_port_data ← R[rb].
  - 12–15: illegal.
- Arithmetic: ADD/SUB/ADDI wrap modulo 2^DATA_W; carry and borrow are discarded. The MUL product is the full 2·DATA_W bits.
- R0: writes to R0 are discarded; R0 reads as 0 on all paths.
- States: IDLE, T_Y, T_Z, T_W, MUL_IT.
  - IDLE: issue_ready = ~clr. On issue_valid & issue_ready the core latches op, ra, rb, rc and imm. Next state is:
    - T_Y for ops 0–7;
    - T_W for ops 8–11;
    - IDLE with done = err = 1 next cycle for ops 12–15.
  - T_Y: bus = R[rb]; Y ← bus. Next state is T_Z for ops 0–6, or MUL_IT for op 7. For MUL, the multiplicand and multiplier latch at this point, and the counter loads DATA_W.
  - T_Z: bus = R[rc] (or imm for ADDI); Z ← ALU(Y, bus). Next state T_W.
  - T_W: bus = Z, HI, LO or in_port_data; destination written at the end of the cycle. OUT writes out_port_data here. Next state IDLE, with done = 1 next cycle.
  - MUL_IT: one shift-add step per cycle; the counter decrements. HI/LO hold partial results and are final at the edge where the counter reaches 0. Next state IDLE, with done = 1 next cycle.
- Operand fields latch at issue, so later changes to the issue inputs have no effect on an operation in flight.
- issue_valid while issue_ready = 0 is ignored; no queueing.
- Same-register hazards: ra = rb = rc is legal. Sources are read in T_Y/T_Z, before the T_W write.

## Timing
- Reset: while clr is high, at every edge:
  - all registers R1..R(N-1), Y, Z, HI, LO and out_port_data ← 0;
  - state ← IDLE; done = err = 0;
  - issue_ready = 0 combinationally.
- clr asserted mid-operation abandons the operation. No partial writeback occurs and no done is generated.
- Latency, counted from the accepting edge to the cycle done is high:
  - ops 0–6: 4 cycles;
  - ops 8–11: 2 cycles;
  - MUL: DATA_W + 2 cycles;
  - illegal: 1 cycle.
- The cycle in which done is high has issue_ready = 1, so back-to-back issue is possible there. Results are visible on dbg_data, hi_data, lo_data and out_port_data in the done cycle.
- done and err are registered single-cycle pulses.

## Test plan
- Reset, then ADDI R1 ← R0 + 5, then ADDI R2 ← R0 + 7, then ADD R3 ← R1 + R2:
  - dbg R3 = 12;
  - done exactly 4 cycles after each accept.
- SUB R4 ← R1 − R2 → 0xFFFFFFFE (wrap). Then ADDI R0 ← R0 + 9 → R0 still reads 0.
- R5 = 0x80000001, R6 = 33, SHR R7 ← R5 >> R6 → 0x40000000 (shift amount is taken mod 32). SHL by 31 → 0x80000000.
- R1 = 0xFFFFFFFF, MUL R1 × R1:
  - HI = 0xFFFFFFFE, LO = 0x00000001;
  - done at 34 cycles.
  - MFHI R8 → R8 = 0xFFFFFFFE, with done at 2 cycles.
- Issue op 13 → done and err both high at 1 cycle, with no register change. A second issue_valid held during a busy MUL is not accepted until issue_ready returns.
- Assert clr during T_Z of an ADD to R9 → R9 stays 0, no done, issue_ready returns low-then-high, and in_port_data → IN/OUT round-trip is correct after reset.

Source files
------------

// File: rtl/bus_datapath_seq_if.sv
// Purpose : bundle of the issue/done handshake, operand fields, I/O port and
//           debug/readback signals between the instruction decoder (master)
//           and the bus_datapath_seq core (slave).
// Signals : issue_valid/issue_ready  - issue handshake
//           op, ra, rb, rc, imm      - instruction fields, latched at issue
//           in_port_data             - external input port value
//           out_port_data            - output port register
//           done, err                - one-cycle completion / illegal-op pulses
//           dbg_sel, dbg_data        - combinational register readback
//           hi_data, lo_data         - multiply result registers
interface bus_datapath_seq_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
);
  localparam int RA_W = $clog2(NUM_REGS);

  logic              issue_valid;
  logic              issue_ready;
  logic [3:0]        op;
  logic [RA_W-1:0]   ra;
  logic [RA_W-1:0]   rb;
  logic [RA_W-1:0]   rc;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] in_port_data;
  logic [DATA_W-1:0] out_port_data;
  logic              done;
  logic              err;
  logic [RA_W-1:0]   dbg_sel;
  logic [DATA_W-1:0] dbg_data;
  logic [DATA_W-1:0] hi_data;
  logic [DATA_W-1:0] lo_data;

  modport slave (
    input  issue_valid, op, ra, rb, rc, imm, in_port_data, dbg_sel,
    output issue_ready, out_port_data, done, err, dbg_data, hi_data, lo_data
  );

  modport master (
    output issue_valid, op, ra, rb, rc, imm, in_port_data, dbg_sel,
    input  issue_ready, out_port_data, done, err, dbg_data, hi_data, lo_data
  );
endinterface

// File: rtl/bus_datapath_seq.sv
// Purpose : single-bus datapath core with an internal control-step sequencer.
//           Each accepted instruction walks T_Y (operand to Y), T_Z (ALU to Z)
//           and T_W (bus to destination); MUL runs an iterative shift-add
//           multiply into HI/LO instead of T_Z/T_W.
// Ports   : clk   - single rising-edge clock
//           clr   - synchronous active-high reset; abandons any operation
//           s_bus - bus_datapath_seq_if.slave (issue handshake, operand
//                   fields, I/O port, done/err, debug and HI/LO readback)
module bus_datapath_seq #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                 clk,
  input  logic                 clr,
  bus_datapath_seq_if.slave    s_bus
);
  localparam int RA_W  = $clog2(NUM_REGS);
  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_MUL  = 4'd7;
  localparam logic [3:0] OP_MFHI = 4'd8;
  localparam logic [3:0] OP_MFLO = 4'd9;
  localparam logic [3:0] OP_IN   = 4'd10;
  localparam logic [3:0] OP_OUT  = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_T_Y    = 3'd1,
    S_T_Z    = 3'd2,
    S_T_W    = 3'd3,
    S_MUL_IT = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_done;
  logic                r_err;
  logic                w_done_nxt;
  logic                w_err_nxt;
  logic                w_ready;
  logic                w_accept;

  logic [3:0]          r_op;
  logic [RA_W-1:0]     r_ra;
  logic [RA_W-1:0]     r_rb;
  logic [RA_W-1:0]     r_rc;
  logic [DATA_W-1:0]   r_imm;

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [DATA_W-1:0]   r_y;
  logic [DATA_W-1:0]   r_z;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic [DATA_W-1:0]   r_mcand;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_out;

  logic [DATA_W-1:0]   w_rd_b;
  logic [DATA_W-1:0]   w_rd_c;
  logic [DATA_W-1:0]   w_bus;
  logic [DATA_W-1:0]   w_alu;
  logic [DATA_W:0]     w_mul_sum;

  // R0 is never written, so every read path forces it to zero explicitly.
  assign w_rd_b = (r_rb == {RA_W{1'b0}}) ? {DATA_W{1'b0}} : r_regs[r_rb];
  assign w_rd_c = (r_rc == {RA_W{1'b0}}) ? {DATA_W{1'b0}} : r_regs[r_rc];

  assign w_ready  = (r_state == S_IDLE) && !clr;
  assign w_accept = s_bus.issue_valid && w_ready;

  // One shift-add step: add the multiplicand into HI when the current
  // multiplier bit (LO[0]) is set; the carry shifts back into HI.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(DATA_W+1){1'b0}});

  // Sequencer next-state and completion-pulse decode.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (s_bus.op <= OP_MUL) begin
            w_state_nxt = S_T_Y;
          end else if (s_bus.op <= OP_OUT) begin
            w_state_nxt = S_T_W;
          end else begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
            w_err_nxt   = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_T_Y: begin
        if (r_op == OP_MUL) begin
          w_state_nxt = S_MUL_IT;
        end else begin
          w_state_nxt = S_T_Z;
        end
      end
      S_T_Z: w_state_nxt = S_T_W;
      S_T_W: begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
      end
      S_MUL_IT: begin
        // The step taken while the counter is 1 is the last of DATA_W steps.
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_MUL_IT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Single internal bus source select per control step.
  always_comb begin
    w_bus = {DATA_W{1'b0}};
    case (r_state)
      S_T_Y: w_bus = w_rd_b;
      S_T_Z: begin
        if (r_op == OP_ADDI) begin
          w_bus = r_imm;
        end else begin
          w_bus = w_rd_c;
        end
      end
      S_T_W: begin
        case (r_op)
          OP_MFHI: w_bus = r_hi;
          OP_MFLO: w_bus = r_lo;
          OP_IN:   w_bus = s_bus.in_port_data;
          OP_OUT:  w_bus = w_rd_b;
          default: w_bus = r_z;
        endcase
      end
      default: w_bus = {DATA_W{1'b0}};
    endcase
  end

  // ALU combining Y with the bus; shifts use only the low log2(DATA_W) bits.
  always_comb begin
    w_alu = {DATA_W{1'b0}};
    case (r_op)
      OP_ADD:  w_alu = r_y + w_bus;
      OP_SUB:  w_alu = r_y - w_bus;
      OP_AND:  w_alu = r_y & w_bus;
      OP_OR:   w_alu = r_y | w_bus;
      OP_SHL:  w_alu = r_y << w_bus[SH_W-1:0];
      OP_SHR:  w_alu = r_y >> w_bus[SH_W-1:0];
      OP_ADDI: w_alu = r_y + w_bus;
      default: w_alu = {DATA_W{1'b0}};
    endcase
  end

  // Sequencer state and registered done/err pulses.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Datapath registers: field latch, Y/Z, multiplier, writeback and out port.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
      r_op    <= 4'd0;
      r_ra    <= {RA_W{1'b0}};
      r_rb    <= {RA_W{1'b0}};
      r_rc    <= {RA_W{1'b0}};
      r_imm   <= {DATA_W{1'b0}};
      r_y     <= {DATA_W{1'b0}};
      r_z     <= {DATA_W{1'b0}};
      r_hi    <= {DATA_W{1'b0}};
      r_lo    <= {DATA_W{1'b0}};
      r_mcand <= {DATA_W{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
      r_out   <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op  <= s_bus.op;
            r_ra  <= s_bus.ra;
            r_rb  <= s_bus.rb;
            r_rc  <= s_bus.rc;
            r_imm <= s_bus.imm;
          end
        end
        S_T_Y: begin
          r_y <= w_bus;
          if (r_op == OP_MUL) begin
            r_mcand <= w_rd_b;
            r_lo    <= w_rd_c;
            r_hi    <= {DATA_W{1'b0}};
            r_cnt   <= CNT_W'(DATA_W);
          end
        end
        S_T_Z: r_z <= w_alu;
        S_T_W: begin
          if (r_op == OP_OUT) begin
            r_out <= w_bus;
          end else if (r_ra != {RA_W{1'b0}}) begin
            r_regs[r_ra] <= w_bus;
          end
        end
        S_MUL_IT: begin
          r_hi  <= w_mul_sum[DATA_W:1];
          r_lo  <= {w_mul_sum[0], r_lo[DATA_W-1:1]};
          r_cnt <= r_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign s_bus.issue_ready   = w_ready;
  assign s_bus.done          = r_done;
  assign s_bus.err           = r_err;
  assign s_bus.out_port_data = r_out;
  assign s_bus.hi_data       = r_hi;
  assign s_bus.lo_data       = r_lo;
  assign s_bus.dbg_data      = (s_bus.dbg_sel == {RA_W{1'b0}}) ? {DATA_W{1'b0}}
                                                               : r_regs[s_bus.dbg_sel];
endmodule

// File: tb/tb_bus_datapath_seq.sv
// Purpose : directed self-checking bench for bus_datapath_seq (DATA_W=32,
//           NUM_REGS=16). Drives the interface master side, checks latency,
//           results, R0 behaviour, illegal opcodes, busy back-pressure,
//           mid-operation reset and the I/O port round trip.
module tb_bus_datapath_seq;
  logic clk;
  logic clr;
  int   n_checks;
  int   n_fail;

  bus_datapath_seq_if #(.DATA_W(32), .NUM_REGS(16)) s ();

  bus_datapath_seq #(.DATA_W(32), .NUM_REGS(16)) dut (
    .clk   (clk),
    .clr   (clr),
    .s_bus (s.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Read a register through the debug port away from the clock edge.
  task automatic chk_reg(input string tag, input logic [3:0] idx, input logic [31:0] exp);
    @(negedge clk);
    s.dbg_sel = idx;
    #1;
    check(tag, s.dbg_data, exp);
  endtask

  // Issue one instruction, scramble the fields after acceptance, and check
  // latency (accept cycle = 0) and err in the done cycle. Returns in the done cycle.
  task automatic issue(input string tag, input logic [3:0] op_i, input logic [3:0] ra_i,
                       input logic [3:0] rb_i, input logic [3:0] rc_i,
                       input logic [31:0] imm_i, input int exp_lat, input logic exp_err);
    int n;
    s.op = op_i; s.ra = ra_i; s.rb = rb_i; s.rc = rc_i; s.imm = imm_i;
    s.issue_valid = 1'b1;
    n = 0;
    while (!s.issue_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_ready"}, 32'(s.issue_ready), 32'd1);
    @(posedge clk); #1;
    s.issue_valid = 1'b0;
    s.op = 4'd13; s.ra = ~ra_i; s.rb = ~rb_i; s.rc = ~rc_i; s.imm = ~imm_i;
    n = 1;
    while (!s.done && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_err"}, 32'(s.err), 32'(exp_err));
  endtask

  initial begin
    int  n;
    logic seen;
    n_checks = 0;
    n_fail   = 0;
    clr = 1'b1;
    s.issue_valid = 1'b0;
    s.op = 4'd0; s.ra = 4'd0; s.rb = 4'd0; s.rc = 4'd0;
    s.imm = 32'd0; s.in_port_data = 32'd0; s.dbg_sel = 4'd1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(s.issue_ready), 32'd0);
    check("rst_done",  32'(s.done), 32'd0);
    check("rst_err",   32'(s.err), 32'd0);
    check("rst_hi",    s.hi_data, 32'd0);
    check("rst_lo",    s.lo_data, 32'd0);
    check("rst_out",   s.out_port_data, 32'd0);
    check("rst_r1",    s.dbg_data, 32'd0);
    clr = 1'b0;
    #1;
    check("rel_ready", 32'(s.issue_ready), 32'd1);

    // ADDI / ADDI / ADD, back-to-back from the done cycle
    issue("addi_r1", 4'd6, 4'd1, 4'd0, 4'd0, 32'd5, 4, 1'b0);
    issue("addi_r2", 4'd6, 4'd2, 4'd0, 4'd0, 32'd7, 4, 1'b0);
    issue("add_r3",  4'd0, 4'd3, 4'd1, 4'd2, 32'd0, 4, 1'b0);
    chk_reg("r3_sum", 4'd3, 32'd12);

    // SUB wrap and R0 write discard
    issue("sub_r4", 4'd1, 4'd4, 4'd1, 4'd2, 32'd0, 4, 1'b0);
    chk_reg("r4_wrap", 4'd4, 32'hFFFF_FFFE);
    issue("addi_r0", 4'd6, 4'd0, 4'd0, 4'd0, 32'd9, 4, 1'b0);
    chk_reg("r0_zero", 4'd0, 32'd0);

    // Shifts: amount taken modulo 32
    issue("set_r5", 4'd6, 4'd5, 4'd0, 4'd0, 32'h8000_0001, 4, 1'b0);
    issue("set_r6", 4'd6, 4'd6, 4'd0, 4'd0, 32'd33, 4, 1'b0);
    issue("shr_r7", 4'd5, 4'd7, 4'd5, 4'd6, 32'd0, 4, 1'b0);
    chk_reg("r7_shr", 4'd7, 32'h4000_0000);
    issue("set_r10", 4'd6, 4'd10, 4'd0, 4'd0, 32'd31, 4, 1'b0);
    issue("shl_r11", 4'd4, 4'd11, 4'd5, 4'd10, 32'd0, 4, 1'b0);
    chk_reg("r11_shl", 4'd11, 32'h8000_0000);

    // Full-width unsigned multiply, then MFHI/MFLO
    issue("set_r1ff", 4'd6, 4'd1, 4'd0, 4'd0, 32'hFFFF_FFFF, 4, 1'b0);
    issue("mul_ff", 4'd7, 4'd0, 4'd1, 4'd1, 32'd0, 34, 1'b0);
    check("mul_hi", s.hi_data, 32'hFFFF_FFFE);
    check("mul_lo", s.lo_data, 32'h0000_0001);
    issue("mfhi_r8", 4'd8, 4'd8, 4'd0, 4'd0, 32'd0, 2, 1'b0);
    chk_reg("r8_hi", 4'd8, 32'hFFFF_FFFE);
    issue("mflo_r12", 4'd9, 4'd12, 4'd0, 4'd0, 32'd0, 2, 1'b0);
    chk_reg("r12_lo", 4'd12, 32'h0000_0001);

    // Illegal opcode: done+err after 1 cycle, single pulses, no register change
    issue("ill13", 4'd13, 4'd2, 4'd0, 4'd0, 32'd0, 1, 1'b1);
    @(posedge clk); #1;
    check("ill_done_pulse", 32'(s.done), 32'd0);
    check("ill_err_pulse",  32'(s.err), 32'd0);
    chk_reg("ill_r2_kept", 4'd2, 32'd7);

    // Busy MUL with a second issue held: R2*R2 = 49, ADDI R13 waits
    s.dbg_sel = 4'd13;
    s.op = 4'd7; s.ra = 4'd0; s.rb = 4'd2; s.rc = 4'd2; s.imm = 32'd0;
    s.issue_valid = 1'b1;
    check("busy_pre_ready", 32'(s.issue_ready), 32'd1);
    @(posedge clk); #1;
    s.op = 4'd6; s.ra = 4'd13; s.rb = 4'd0; s.rc = 4'd0; s.imm = 32'd3;
    check("busy_ready", 32'(s.issue_ready), 32'd0);
    n = 1;
    while (!s.done && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("busy_mul_lat", 32'(n), 32'd34);
    check("busy_mul_lo", s.lo_data, 32'd49);
    check("busy_mul_hi", s.hi_data, 32'd0);
    check("busy_r13_untouched", s.dbg_data, 32'd0);
    check("busy_done_ready", 32'(s.issue_ready), 32'd1);
    @(posedge clk); #1;
    s.issue_valid = 1'b0;
    n = 1;
    while (!s.done && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("held_addi_lat", 32'(n), 32'd4);
    check("held_addi_r13", s.dbg_data, 32'd3);

    // clr during T_Z of ADD R9 <- R1 + R2
    s.op = 4'd0; s.ra = 4'd9; s.rb = 4'd1; s.rc = 4'd2; s.imm = 32'd0;
    s.issue_valid = 1'b1;
    @(posedge clk); #1;
    s.issue_valid = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    check("clr_ready_low", 32'(s.issue_ready), 32'd0);
    check("clr_done", 32'(s.done), 32'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    #1;
    check("clr_ready_high", 32'(s.issue_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      seen = seen | s.done;
    end
    check("clr_no_done", 32'(seen), 32'd0);
    chk_reg("clr_r9", 4'd9, 32'd0);
    chk_reg("clr_r1", 4'd1, 32'd0);
    check("clr_lo", s.lo_data, 32'd0);

    // IN / OUT round trip after reset
    s.in_port_data = 32'hA5A5_1234;
    issue("in_r14", 4'd10, 4'd14, 4'd0, 4'd0, 32'd0, 2, 1'b0);
    chk_reg("r14_in", 4'd14, 32'hA5A5_1234);
    s.in_port_data = 32'd0;
    issue("out_r14", 4'd11, 4'd0, 4'd14, 4'd0, 32'd0, 2, 1'b0);
    check("out_port", s.out_port_data, 32'hA5A5_1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
